// File: rtl/cnt_pkg.sv
// cnt_pkg: shared state encoding, mode constants and helpers for the interval timer controller
package cnt_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
  function automatic logic is_active(input state_t s);
    return s != IDLE;
  endfunction
endpackage

// File: rtl/cnt_seq_ctrl_if.sv
// cnt_seq_ctrl_if: command/status bundle between software-facing logic (master) and the timer controller (slave)
// start/stop/mode/terminal flow master->slave; count/busy/tick/done flow slave->master
interface cnt_seq_ctrl_if #(parameter int WIDTH = 4);
  logic             start;
  logic             stop;
  logic             mode;
  logic [WIDTH-1:0] terminal;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tick;
  logic             done;
  modport master (output start, stop, mode, terminal, input count, busy, tick, done);
  modport slave  (input start, stop, mode, terminal, output count, busy, tick, done);
endinterface

// File: rtl/cnt_core.sv
// cnt_core: WIDTH-bit synchronous up counter; clr beats en; ports clk, rst (async high), en, clr, q
module cnt_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= q + WIDTH'(1);
endmodule

// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: run/pause/stop sequencer turning cnt_core into a one-shot or periodic interval timer
// Ports: clk, rst (async active-high), bus (cnt_seq_ctrl_if.slave: start, stop, mode, terminal -> count, busy, tick, done)
// Optional CNT_PRESCALE_EN: count advances every PRESCALE-th RUN cycle instead of every RUN cycle
module cnt_seq_ctrl
  import cnt_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input logic           clk,
  input logic           rst,
  cnt_seq_ctrl_if.slave bus
);
  if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
    $error("PRESCALE must be within 1..256");
  end
  state_t           state, nxt;
  logic             mode_q;
  logic [WIDTH-1:0] term_q;
  logic [WIDTH-1:0] q;
  logic             en, clr, launch, adv, tick_d, done_d;
  logic             busy_q, tick_q, done_q;
  cnt_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk),
    .rst(rst),
    .en (en),
    .clr(clr),
    .q  (q)
  );
`ifdef CNT_PRESCALE_EN
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre;
  assign adv = pre == PW'(PRESCALE - 1);
  // phase runs only in RUN without stop, so a pause freezes it mid-period
  always_ff @(posedge clk or posedge rst)
    if (rst) pre <= '0;
    else if (launch || (state == PAUSE && bus.stop)) pre <= '0;
    else if (state == RUN && !bus.stop) pre <= adv ? '0 : pre + PW'(1);
`else
  assign adv = 1'b1;
`endif
  always_comb begin
    nxt    = state;
    en     = 1'b0;
    clr    = 1'b0;
    launch = 1'b0;
    tick_d = 1'b0;
    done_d = 1'b0;
    case (state)
      IDLE:
        if (bus.start && !bus.stop) begin
          nxt    = RUN;
          clr    = 1'b1;
          launch = 1'b1;
        end
      RUN:
        // stop wins over a pending terminal advance: no tick, count frozen
        if (bus.stop) nxt = PAUSE;
        else if (adv && q == term_q) begin
          clr    = 1'b1;
          tick_d = 1'b1;
          done_d = mode_q == MODE_ONESHOT;
          nxt    = mode_q == MODE_ONESHOT ? IDLE : RUN;
        end else en = adv;
      PAUSE:
        if (bus.stop) begin
          nxt = IDLE;
          clr = 1'b1;
        end else if (bus.start) nxt = RUN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      mode_q <= MODE_ONESHOT;
      term_q <= '0;
      busy_q <= 1'b0;
      tick_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= nxt;
      busy_q <= is_active(nxt);
      tick_q <= tick_d;
      done_q <= done_d;
      if (launch) begin
        mode_q <= bus.mode;
        term_q <= bus.terminal;
      end
    end
  assign bus.count = q;
  assign bus.busy  = busy_q;
  assign bus.tick  = tick_q;
  assign bus.done  = done_q;
endmodule
